inverter_1bit: RTL and testbench

- Registered, flow-controlled bitwise inverter: each accepted word `a` is emitted as `result = ~a`, bit for bit.
- Sits in the datapath as a stand-alone logic-unit stage between a valid/ready producer and consumer.
- Full throughput (one word per cycle) via a 2-entry skid buffer; 1-cycle latency.

---
 rtl/inverter_1bit_pkg.sv | 18 +
 rtl/inverter_1bit_skid.sv | 85 ++++++++
 rtl/inverter_1bit.sv | 63 ++++++
 tb/tb_inverter_1bit.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/inverter_1bit_pkg.sv
// Shared types and helpers for the registered bitwise inverter stage.
package inverter_1bit_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef logic [DEFAULT_WIDTH-1:0] data_t;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_state_t;

   function automatic data_t invert(input data_t d);
      return ~d;
   endfunction

endpackage

// File: rtl/inverter_1bit_skid.sv
// Generic 2-entry valid/ready skid buffer; in_ready is a decode of registered state only.
//
// state      | meaning
// -----------+-----------------------------------------------
// SKID_EMPTY | no word held, out_valid=0, main register is 0
// SKID_ONE   | main holds the head word, skid register empty
// SKID_TWO   | main holds head, skid holds next word, in_ready=0
module inverter_1bit_skid
   import inverter_1bit_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   skid_state_t  state_q, state_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         in_xfer;
   logic         out_xfer;

   assign in_ready  = (state_q != SKID_TWO);
   assign out_valid = (state_q != SKID_EMPTY);
   assign out_data  = main_q;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SKID_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         SKID_EMPTY: begin
            if (in_xfer) begin
               state_d = SKID_ONE;
               main_d  = in_data;
            end
         end
         SKID_ONE: begin
            if (in_xfer && out_xfer) begin
               main_d = in_data;
            end else if (in_xfer) begin
               state_d = SKID_TWO;
               skid_d  = in_data;
            end else if (out_xfer) begin
               // Clear on drain so an empty buffer never shows stale data.
               state_d = SKID_EMPTY;
               main_d  = '0;
            end
         end
         SKID_TWO: begin
            if (out_xfer) begin
               state_d = SKID_ONE;
               main_d  = skid_q;
               skid_d  = '0;
            end
         end
         default: begin
            state_d = SKID_EMPTY;
            main_d  = '0;
            skid_d  = '0;
         end
      endcase
   end

endmodule

// File: rtl/inverter_1bit.sv
// Registered, flow-controlled bitwise inverter (result = ~a) with 1-cycle latency.
// Define INVERTER_1BIT_PARITY_EN to add a registered out_parity (XOR of result).
module inverter_1bit
   import inverter_1bit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
`ifdef INVERTER_1BIT_PARITY_EN
   ,
   output logic             out_parity
`endif
);

   logic [WIDTH-1:0] inv;

   generate
      if (WIDTH == DEFAULT_WIDTH) begin : g_pkg_inv
         assign inv = WIDTH'(invert(data_t'(a)));
      end else begin : g_gen_inv
         assign inv = ~a;
      end
   endgenerate

`ifdef INVERTER_1BIT_PARITY_EN
   localparam int PW = WIDTH + 1;
   logic [PW-1:0] payload_in;
   logic [PW-1:0] payload_out;

   // Parity travels with the data word so it obeys the same hold rules.
   assign payload_in = {^inv, inv};
   assign result     = payload_out[WIDTH-1:0];
   assign out_parity = payload_out[WIDTH];
`else
   localparam int PW = WIDTH;
   logic [PW-1:0] payload_in;
   logic [PW-1:0] payload_out;

   assign payload_in = inv;
   assign result     = payload_out;
`endif

   inverter_1bit_skid #(
      .W (PW)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (payload_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (payload_out)
   );

endmodule

// File: tb/tb_inverter_1bit.sv
// Self-checking bench for inverter_1bit: directed plan steps plus random traffic vs a FIFO model.
module tb_inverter_1bit;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
`ifdef INVERTER_1BIT_PARITY_EN
   logic             out_parity;
`endif

   int checks;
   int failures;

   // Reference: words in acceptance order, at most two outstanding.
   logic [WIDTH-1:0] mq[$];

   inverter_1bit #(
      .WIDTH (WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
`ifdef INVERTER_1BIT_PARITY_EN
      ,
      .out_parity (out_parity)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
   task automatic step(input logic r, input logic iv, input logic [63:0] av, input logic ordy);
      logic [WIDTH-1:0] exp_res;
      logic             exp_ov;
      logic             exp_ir;
      logic             acc;
      logic             pop;
      rst       = r;
      in_valid  = iv;
      a         = WIDTH'(av);
      out_ready = ordy;
      @(negedge clk);
      exp_ov  = (mq.size() != 0);
      exp_ir  = (mq.size() < 2);
      exp_res = exp_ov ? mq[0] : '0;
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      chk("result", 64'(result), 64'(exp_res));
`ifdef INVERTER_1BIT_PARITY_EN
      chk("out_parity", 64'(out_parity), 64'(^exp_res));
`endif
      if (r) begin
         mq.delete();
      end else begin
         pop = exp_ov && ordy;
         acc = iv && exp_ir;
         if (pop) void'(mq.pop_front());
         if (acc) mq.push_back(~WIDTH'(av));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Streaming at full rate.
      step(0, 1, 64'h00, 1);
      step(0, 1, 64'hFF, 1);
      step(0, 1, 64'hAD, 1);
      step(0, 1, 64'hD6, 1);
      step(0, 0, 64'h00, 1);
      step(0, 0, 64'h00, 1);

      // Backpressure fills skid, third word refused, then drain in order.
      step(0, 1, 64'hAD, 0);
      step(0, 1, 64'hD6, 0);
      step(0, 1, 64'h77, 0);
      step(0, 0, 64'h00, 0);
      step(0, 0, 64'h00, 1);
      step(0, 0, 64'h00, 1);
      step(0, 0, 64'h00, 1);

      // Bubbles, with junk on a while in_valid is low.
      step(0, 1, 64'hF0, 1);
      step(0, 0, 64'h5A, 1);
      step(0, 1, 64'h0F, 1);
      step(0, 0, 64'hC3, 1);
      step(0, 0, 64'h00, 1);

      // Reset mid-stream discards both buffered words.
      step(0, 1, 64'h11, 0);
      step(0, 1, 64'h22, 0);
      step(1, 1, 64'h33, 1);
      step(0, 0, 64'h00, 1);
      step(0, 1, 64'h44, 1);
      step(0, 0, 64'h00, 1);

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 3) != 0),
              {$urandom, $urandom},
              ($urandom_range(0, 2) != 0));
      end

      step(0, 0, 64'h00, 1);
      step(0, 0, 64'h00, 1);
      step(0, 0, 64'h00, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
